// File: rtl/div_iter_pkg.sv
// div_iter_pkg: state encoding and default operand width shared by the
// iterative divider files.
package div_iter_pkg;

   localparam int K_DEFAULT = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/div_iter_sub_k1.sv
// div_iter_sub_k1: combinational W-bit subtractor; borrow is set when a < b.
module div_iter_sub_k1 #(
   parameter int W = 33
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] diff,
   output logic         borrow
);

   assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/div_iter.sv
// div_iter: iterative restoring divider, one quotient bit per cycle, unsigned
// or two's-complement, with divide-by-zero and signed-overflow flags.
//
// state | meaning
// IDLE  | waiting for start; results hold
// RUN   | one restoring step per cycle for k cycles
// DONE  | result just registered, done pulses; a new start is accepted here
module div_iter
   import div_iter_pkg::*;
#(
   parameter int k = K_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         sign,
   input  logic [k-1:0] X,
   input  logic [k-1:0] Y,
   output logic         busy,
   output logic         done,
   output logic [k-1:0] Q,
   output logic [k-1:0] R,
   output logic         DivZero,
   output logic         DivOverflow
);

   localparam int CW = $clog2(k);
   localparam logic [k-1:0] MOST_NEG = {1'b1, {(k-1){1'b0}}};

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic [k-1:0]  rem, quo, dmag;
   logic          neg_q, neg_r, dz, ov;
   logic          accept, last, take;
   logic [k:0]    sub_a, sub_b, sub_d;
   logic          borrow;
   logic [k-1:0]  rem_nxt, quo_nxt;

   assign accept = start && (state != RUN);
   assign last   = (state == RUN) && (cnt == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            busy = 1'b1;
            if (cnt == '0) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = start ? RUN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Partial remainder shifted left with the next dividend bit from quo's MSB.
   assign sub_a = {rem, quo[k-1]};
   assign sub_b = {1'b0, dmag};

   div_iter_sub_k1 #(.W(k + 1)) sub_k1 (
      .a      (sub_a),
      .b      (sub_b),
      .diff   (sub_d),
      .borrow (borrow)
   );

   // A valid difference is non-negative and below the divisor, so its MSB is clear.
   assign take    = ~borrow & ~sub_d[k];
   assign rem_nxt = take ? sub_d[k-1:0] : sub_a[k-1:0];
   assign quo_nxt = {quo[k-2:0], take};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt         <= '0;
         rem         <= '0;
         quo         <= '0;
         dmag        <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         dz          <= 1'b0;
         ov          <= 1'b0;
         Q           <= '0;
         R           <= '0;
         DivZero     <= 1'b0;
         DivOverflow <= 1'b0;
      end else if (accept) begin
         cnt   <= CW'(k - 1);
         rem   <= '0;
         quo   <= (sign && X[k-1]) ? -X : X;
         dmag  <= (sign && Y[k-1]) ? -Y : Y;
         neg_q <= sign && (X[k-1] ^ Y[k-1]);
         neg_r <= sign && X[k-1];
         dz    <= (Y == '0);
         ov    <= sign && (X == MOST_NEG) && (Y == '1);
      end else if (state == RUN) begin
         rem <= rem_nxt;
         quo <= quo_nxt;
         if (cnt != '0) cnt <= cnt - CW'(1);
         if (last) begin
            // Zero divisor yields |X| naturally; only the signed quotient needs forcing.
            Q           <= dz ? '1 : (neg_q ? -quo_nxt : quo_nxt);
            R           <= neg_r ? -rem_nxt : rem_nxt;
            DivZero     <= dz;
            DivOverflow <= ov;
         end
      end
   end

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: randomized and directed stimulus with a queue-based scoreboard
// checked against an arithmetic reference model.
module tb_div_iter;

   localparam int K = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         sign = 1'b0;
   logic [K-1:0] X = '0;
   logic [K-1:0] Y = '0;
   logic         busy, done, DivZero, DivOverflow;
   logic [K-1:0] Q, R;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int busy_cnt = 0;

   typedef struct {
      logic [K-1:0] q;
      logic [K-1:0] r;
      logic         dz;
      logic         ov;
      int           t;
   } exp_t;

   exp_t sb[$];
   exp_t last_exp;

   div_iter #(.k(K)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .sign        (sign),
      .X           (X),
      .Y           (Y),
      .busy        (busy),
      .done        (done),
      .Q           (Q),
      .R           (R),
      .DivZero     (DivZero),
      .DivOverflow (DivOverflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t model(input logic [K-1:0] x, input logic [K-1:0] y, input logic s);
      exp_t e;
      e.dz = (y == 0);
      e.ov = s && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
      if (e.dz) begin
         e.q = 32'hFFFF_FFFF;
         e.r = x;
      end else if (e.ov) begin
         e.q = x;
         e.r = 0;
      end else if (s) begin
         e.q = $signed(x) / $signed(y);
         e.r = $signed(x) % $signed(y);
      end else begin
         e.q = x / y;
         e.r = x % y;
      end
      e.t = 0;
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst_n) begin
         busy_cnt = 0;
      end else begin
         if (busy) busy_cnt++;
         if (done) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_done: done=1 with nothing outstanding at cycle %0d", cyc);
            end else begin
               e = sb.pop_front();
               chk("latency", cyc - e.t, K);
               chk("busy_cycles", busy_cnt, K);
               chk("Q", Q, e.q);
               chk("R", R, e.r);
               chk("DivZero", DivZero, e.dz);
               chk("DivOverflow", DivOverflow, e.ov);
            end
            busy_cnt = 0;
         end
      end
   end

   task automatic issue(input logic [K-1:0] x, input logic [K-1:0] y, input logic s);
      exp_t e;
      start = 1'b1;
      X     = x;
      Y     = y;
      sign  = s;
      @(posedge clk);
      #1;
      e   = model(x, y, s);
      e.t = cyc;
      sb.push_back(e);
      last_exp = e;
      start = 1'b0;
      X     = $urandom;
      Y     = $urandom;
      sign  = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 200);
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: no done within %0d cycles", n);
      end
   endtask

   task automatic check_hold();
      repeat (3) @(negedge clk);
      chk("hold_Q", Q, last_exp.q);
      chk("hold_R", R, last_exp.r);
      chk("hold_DivZero", DivZero, last_exp.dz);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_Q"}, Q, 0);
      chk({tag, "_R"}, R, 0);
      chk({tag, "_DivZero"}, DivZero, 0);
      chk({tag, "_DivOverflow"}, DivOverflow, 0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      logic [K-1:0] x, y;
      logic         s;
      int           mode;

      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      issue(32'd100, 32'd7, 1'b0);
      wait_done();
      check_hold();

      issue(32'hFFFF_FF9C, 32'd7, 1'b1);
      wait_done();
      // back-to-back: start taken in the DONE cycle
      issue(32'h1234_5678, 32'd0, 1'b0);
      wait_done();
      issue(32'h8765_4321, 32'd0, 1'b1);
      wait_done();
      issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      wait_done();
      check_hold();
      issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      wait_done();
      issue(32'd5, 32'd9, 1'b1);
      wait_done();
      issue(32'h8000_0000, 32'd1, 1'b1);
      wait_done();

      // a start while busy must be ignored
      issue(32'd1000, 32'd3, 1'b0);
      repeat (5) @(negedge clk);
      start = 1'b1;
      X     = 32'd555;
      Y     = 32'd2;
      sign  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      check_hold();
      repeat (40) @(negedge clk);

      // reset mid-run, asserted together with start
      issue(32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      sb.delete();
      check_zero("midrun_reset");
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("after_reset_Q", Q, 0);
      issue(32'd77, 32'd5, 1'b0);
      wait_done();

      for (int i = 0; i < 24; i++) begin
         x    = $urandom;
         s    = 1'($urandom_range(0, 1));
         mode = $urandom_range(0, 9);
         case (mode)
            0:       y = 0;
            1:       y = $urandom_range(1, 15);
            2: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            3:       y = -($urandom_range(1, 15));
            4:       y = x + 1;
            default: y = $urandom;
         endcase
         issue(x, y, s);
         wait_done();
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 SHALL have parameter k, default 32, giving the operand and result width in bits (k >= 4).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: the reset, which is synchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: the request strobe, sampled high with the operands.
REQ-005 SHALL have port sign, input, 1 bit: 1 selects a two's-complement divide, 0 an unsigned divide.
REQ-006 SHALL have port X, input, k bits: the dividend.
REQ-007 SHALL have port Y, input, k bits: the divisor.
REQ-008 SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-009 SHALL have port done, output, 1 bit: a one-cycle pulse when Q, R and the flags become valid.
REQ-010 SHALL have port Q, output, k bits: the quotient, registered.
REQ-011 SHALL have port R, output, k bits: the remainder, registered.
REQ-012 SHALL have port DivZero, output, 1 bit: high when the captured Y was 0.
REQ-013 SHALL have port DivOverflow, output, 1 bit: high for a signed divide of the most negative value by -1.

Function
REQ-014 SHALL implement three states: IDLE, RUN and DONE.
REQ-015 SHALL accept start only in IDLE or DONE, capturing X, Y and sign at that edge and entering RUN.
REQ-016 SHALL ignore start while in RUN, with no effect on the captured operands, the count or the outputs.
REQ-017 SHALL, in RUN, perform one restoring step per cycle, for exactly k cycles:
  - shift the partial remainder left by 1, bringing in the next dividend bit;
  - subtract the divisor magnitude with a (k+1)-bit subtraction;
  - keep the difference and set the quotient bit to 1 when the difference is non-negative;
  - otherwise restore the partial remainder and set the quotient bit to 0.
REQ-018 SHALL, when sign=1, operate on operand magnitudes and then apply sign correction:
  - Q is negated when the signs of X and Y differ;
  - R takes the sign of X.
REQ-019 SHALL time a request accepted at edge T as follows:
  - busy is high for cycles T+1 through T+k;
  - done is high in cycle T+k+1 only;
  - Q, R, DivZero and DivOverflow update at that edge.
REQ-020 SHALL hold Q, R and the flags stable after done until the next accepted start.
REQ-021 SHALL still take the full latency when Y=0, and SHALL then give Q = all ones, R = X and DivZero=1, for both signed and unsigned operation.
REQ-022 SHALL give Q = X, R = 0 and DivOverflow=1 for sign=1, X = 2^(k-1) and Y = all ones.
REQ-023 SHALL clear DivZero and DivOverflow at every result update where their condition is false.
REQ-024 SHALL allow start to be accepted in the DONE cycle itself: done pulses and the next RUN begins at the following edge.

Reset
REQ-025 SHALL, whenever rst_n=0 at a rising edge, including mid-RUN, do all of the following:
  - go to IDLE;
  - set busy, done, Q, R, DivZero and DivOverflow to 0;
  - clear the step counter;
  - discard any operation in progress, with no done pulse produced for it.
REQ-026 SHALL give rst_n priority over start in the same cycle.

Structure
REQ-027 SHALL take the state encoding (IDLE/RUN/DONE) and the default width constant from the shared CPU package.
REQ-028 SHALL instantiate one sub-module, sub_k1: a combinational (k+1)-bit subtractor with a borrow output, reused every RUN cycle.

Verification
REQ-029 SHALL pass unsigned divide: k=32, X=100, Y=7, sign=0 -> done at T+33, Q=14, R=2, both flags 0.
REQ-030 SHALL pass signed divide: X=-100 (0xFFFFFF9C), Y=7, sign=1 -> Q=0xFFFFFFF2 (-14), R=0xFFFFFFFE (-2).
REQ-031 SHALL pass divide by zero: X=0x12345678, Y=0 -> at T+33, Q=0xFFFFFFFF, R=0x12345678, DivZero=1.
REQ-032 SHALL pass signed overflow: X=0x80000000, Y=0xFFFFFFFF, sign=1 -> Q=0x80000000, R=0, DivOverflow=1.
REQ-033 SHALL pass start while busy: a second start at T+5 with different operands -> first result unchanged, single done at T+33.
REQ-034 SHALL pass reset mid-RUN: rst_n=0 at T+10 -> IDLE with all outputs 0, no done; a new start afterwards completes normally.
